// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Parametrised multi-port register file with hardwired-zero x0,
//             optional same-cycle write-to-read bypass and a hardware clear
//             sweep after reset or on request.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADR_WIDTH  = 5,
  parameter int NUM_READ   = 2,
  parameter int NUM_WRITE  = 1,
  parameter int BYPASS     = 1,
  parameter int DEBUG_REG  = 10
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clr,
  input  logic [NUM_READ*ADR_WIDTH-1:0]   ra,
  output logic [NUM_READ*DATA_WIDTH-1:0]  rd,
  input  logic [NUM_WRITE-1:0]            we,
  input  logic [NUM_WRITE*ADR_WIDTH-1:0]  wa,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wd,
  output logic                            ready,
  output logic [DATA_WIDTH-1:0]           dbg_data
);

  localparam int                   c_DEPTH = 2**ADR_WIDTH;
  localparam logic [ADR_WIDTH-1:0] c_LAST  = ADR_WIDTH'(c_DEPTH - 1);
  localparam logic [ADR_WIDTH-1:0] c_DBG   = ADR_WIDTH'(DEBUG_REG);

  typedef enum logic [0:0] {
    S_CLEAR = 1'b0,
    S_READY = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [ADR_WIDTH-1:0]   r_clr_cnt;
  logic [ADR_WIDTH-1:0]   w_clr_cnt_nxt;
  logic                   w_ready;

  // Entry 0 is never written or swept; every read path forces it to zero.
  logic [DATA_WIDTH-1:0]  r_mem [c_DEPTH];

  // Unpacked views of the write ports; a write to x0 never counts as valid.
  logic [ADR_WIDTH-1:0]   w_wa [NUM_WRITE];
  logic [DATA_WIDTH-1:0]  w_wd [NUM_WRITE];
  logic [NUM_WRITE-1:0]   w_wr_ok;

  generate
    for (genvar j = 0; j < NUM_WRITE; j++) begin : g_wp
      assign w_wa[j]    = wa[j*ADR_WIDTH +: ADR_WIDTH];
      assign w_wd[j]    = wd[j*DATA_WIDTH +: DATA_WIDTH];
      assign w_wr_ok[j] = we[j] && (w_wa[j] != '0);
    end
  endgenerate

  assign w_ready = (r_state == S_READY);
  assign ready   = w_ready;

  // State register and sweep pointer; reset restarts the sweep from entry 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_CLEAR;
      r_clr_cnt <= ADR_WIDTH'(1);
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  // Next state: sweep until the last entry is written, leave READY on clr.
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      S_CLEAR: begin
        w_clr_cnt_nxt = r_clr_cnt + ADR_WIDTH'(1);
        if (r_clr_cnt == c_LAST) begin
          w_state_nxt = S_READY;
        end
      end
      S_READY: begin
        if (clr) begin
          w_state_nxt   = S_CLEAR;
          w_clr_cnt_nxt = ADR_WIDTH'(1);
        end
      end
      default: begin
        w_state_nxt   = S_CLEAR;
        w_clr_cnt_nxt = ADR_WIDTH'(1);
      end
    endcase
  end

  // Array update: the sweep zeroes one entry per cycle; in READY the enabled
  // ports are applied in ascending order so the highest port wins a conflict.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_clr_cnt] <= '0;
    end else begin
      for (int j = 0; j < NUM_WRITE; j++) begin
        if (w_wr_ok[j]) begin
          r_mem[w_wa[j]] <= w_wd[j];
        end
      end
    end
  end

  generate
    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
      logic [ADR_WIDTH-1:0]  w_ra;
      logic [DATA_WIDTH-1:0] w_rdata;

      assign w_ra = ra[i*ADR_WIDTH +: ADR_WIDTH];

      // Read mux: stored value, overridden by the highest matching write port.
      always_comb begin
        w_rdata = '0;
        if (w_ready && (w_ra != '0)) begin
          w_rdata = r_mem[w_ra];
          if (BYPASS != 0) begin
            for (int j = 0; j < NUM_WRITE; j++) begin
              if (w_wr_ok[j] && (w_wa[j] == w_ra)) begin
                w_rdata = w_wd[j];
              end
            end
          end
        end
      end

      assign rd[i*DATA_WIDTH +: DATA_WIDTH] = w_rdata;
    end
  endgenerate

  // Debug tap shows the stored value only, never bypassed write data.
  assign dbg_data = (w_ready && (c_DBG != '0)) ? r_mem[c_DBG] : '0;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : Self-checking bench for regfile_mp. Two instances share stimulus:
//             dut0 (2 write ports, bypass on) and dut1 (1 write port, no
//             bypass). Directed vector table, random traffic against an
//             array-based reference model, and clear/reset sweep sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [9:0]  ra;
  logic [1:0]  we;
  logic [9:0]  wa;
  logic [63:0] wd;

  logic [63:0] rd0, rd1;
  logic        ready0, ready1;
  logic [31:0] dbg0, dbg1;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: plain arrays plus a count of sweep cycles still pending.
  logic [31:0] m0 [32];
  logic [31:0] m1 [32];
  int          busy_left;

  always #5 clk = ~clk;

  regfile_mp #(
    .DATA_WIDTH(32), .ADR_WIDTH(5), .NUM_READ(2), .NUM_WRITE(2),
    .BYPASS(1), .DEBUG_REG(10)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ra(ra), .rd(rd0),
    .we(we), .wa(wa), .wd(wd), .ready(ready0), .dbg_data(dbg0)
  );

  regfile_mp #(
    .DATA_WIDTH(32), .ADR_WIDTH(5), .NUM_READ(2), .NUM_WRITE(1),
    .BYPASS(0), .DEBUG_REG(10)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .ra(ra), .rd(rd1),
    .we(we[0:0]), .wa(wa[4:0]), .wd(wd[31:0]), .ready(ready1), .dbg_data(dbg1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic bit model_busy();
    return (!rst_n) || (busy_left > 0);
  endfunction

  function automatic logic [31:0] exp_rd0(input int i);
    logic [4:0]  a;
    logic [31:0] r;
    a = ra[i*5 +: 5];
    if (model_busy() || a == 5'd0) return 32'h0;
    r = m0[a];
    for (int j = 0; j < 2; j++)
      if (we[j] && wa[j*5 +: 5] == a) r = wd[j*32 +: 32];
    return r;
  endfunction

  function automatic logic [31:0] exp_rd1(input int i);
    logic [4:0] a;
    a = ra[i*5 +: 5];
    if (model_busy() || a == 5'd0) return 32'h0;
    return m1[a];
  endfunction

  task automatic model_zero();
    for (int k = 0; k < 32; k++) begin
      m0[k] = 32'h0;
      m1[k] = 32'h0;
    end
  endtask

  task automatic check_outputs();
    chk("ready0", {31'h0, ready0}, {31'h0, !model_busy()});
    chk("ready1", {31'h0, ready1}, {31'h0, !model_busy()});
    chk("d0_rd0", rd0[31:0],  exp_rd0(0));
    chk("d0_rd1", rd0[63:32], exp_rd0(1));
    chk("d1_rd0", rd1[31:0],  exp_rd1(0));
    chk("d1_rd1", rd1[63:32], exp_rd1(1));
    chk("dbg0", dbg0, model_busy() ? 32'h0 : m0[10]);
    chk("dbg1", dbg1, model_busy() ? 32'h0 : m1[10]);
  endtask

  // One rising edge applied to the model, then return at the next falling edge.
  task automatic advance();
    @(posedge clk);
    if (!rst_n) begin
      busy_left = 31;
      model_zero();
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      for (int j = 0; j < 2; j++)
        if (we[j] && wa[j*5 +: 5] != 5'd0) m0[wa[j*5 +: 5]] = wd[j*32 +: 32];
      if (we[0] && wa[4:0] != 5'd0) m1[wa[4:0]] = wd[31:0];
      if (clr) begin
        busy_left = 31;
        model_zero();
      end
    end
    @(negedge clk);
  endtask

  task automatic step();
    #1;
    check_outputs();
    advance();
  endtask

  task automatic wait_ready(input int exp_cycles);
    int n;
    n = 0;
    while (!ready0 && n < 100) begin
      step();
      n++;
    end
    chk("sweep_len", 32'(n), 32'(exp_cycles));
  endtask

  task automatic read_all();
    we = 2'b00;
    clr = 1'b0;
    for (int i = 0; i < 32; i++) begin
      ra = {5'(31 - i), 5'(i)};
      step();
    end
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] e_rd0;   // dut0 port 0
    logic [31:0] e_rd1;   // dut0 port 1
    logic [31:0] e_nb1;   // dut1 port 1 (no bypass, single write port)
    logic [31:0] e_dbg;   // both debug taps
  } vec_t;

  vec_t vecs [10];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{2'b01, 5'd10, 32'hDEADBEEF, 5'd0, 32'h0,        5'd5,  5'd10, 32'h0,        32'hDEADBEEF, 32'h0,        32'h0};
    vecs[1] = '{2'b00, 5'd10, 32'h0,        5'd0, 32'h0,        5'd10, 5'd10, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[2] = '{2'b11, 5'd7,  32'h11,       5'd7, 32'h22,       5'd7,  5'd7,  32'h22,       32'h22,       32'h0,        32'hDEADBEEF};
    vecs[3] = '{2'b00, 5'd7,  32'h0,        5'd7, 32'h0,        5'd7,  5'd7,  32'h22,       32'h22,       32'h11,       32'hDEADBEEF};
    vecs[4] = '{2'b01, 5'd0,  32'h1234,     5'd0, 32'h0,        5'd0,  5'd0,  32'h0,        32'h0,        32'h0,        32'hDEADBEEF};
    vecs[5] = '{2'b00, 5'd0,  32'h0,        5'd0, 32'h0,        5'd0,  5'd1,  32'h0,        32'h0,        32'h0,        32'hDEADBEEF};
    vecs[6] = '{2'b10, 5'd3,  32'h1,        5'd3, 32'hAAAA5555, 5'd3,  5'd3,  32'hAAAA5555, 32'hAAAA5555, 32'h0,        32'hDEADBEEF};
    vecs[7] = '{2'b00, 5'd3,  32'h0,        5'd3, 32'h0,        5'd3,  5'd3,  32'hAAAA5555, 32'hAAAA5555, 32'h0,        32'hDEADBEEF};
    vecs[8] = '{2'b11, 5'd10, 32'hCAFEF00D, 5'd9, 32'h5,        5'd10, 5'd9,  32'hCAFEF00D, 32'h5,        32'h0,        32'hDEADBEEF};
    vecs[9] = '{2'b00, 5'd10, 32'h0,        5'd9, 32'h0,        5'd10, 5'd9,  32'hCAFEF00D, 32'h5,        32'h0,        32'hCAFEF00D};

    // Reset state and the power-up sweep with ra held at 5.
    rst_n = 1'b0; clr = 1'b0; we = 2'b00; wa = '0; wd = '0; ra = {5'd5, 5'd5};
    busy_left = 31;
    model_zero();
    @(negedge clk);
    step();
    step();
    rst_n = 1'b1;
    wait_ready(31);
    #1;
    chk("post_sweep_rd0", rd0[31:0], 32'h0);

    // Directed vector table.
    for (int v = 0; v < 10; v++) begin
      we = vecs[v].we;
      wa = {vecs[v].wa1, vecs[v].wa0};
      wd = {vecs[v].wd1, vecs[v].wd0};
      ra = {vecs[v].ra1, vecs[v].ra0};
      #1;
      chk("vec_d0_rd0", rd0[31:0],  vecs[v].e_rd0);
      chk("vec_d0_rd1", rd0[63:32], vecs[v].e_rd1);
      chk("vec_d1_rd1", rd1[63:32], vecs[v].e_nb1);
      chk("vec_dbg0",   dbg0,       vecs[v].e_dbg);
      chk("vec_dbg1",   dbg1,       vecs[v].e_dbg);
      advance();
    end

    // Random traffic, including occasional clear requests.
    for (int n = 0; n < 400; n++) begin
      clr = ($urandom_range(0, 59) == 0);
      we  = 2'($urandom_range(0, 3));
      wa  = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      wd  = {$urandom, $urandom};
      ra  = {5'($urandom_range(0, 15)), 5'($urandom_range(0, 15))};
      step();
    end
    clr = 1'b0; we = 2'b00;
    wait_ready(busy_left);

    // Fill x1..x31 with their index, read back, then clear with writes during the sweep.
    for (int i = 1; i < 32; i++) begin
      we = 2'b01;
      wa = {5'd0, 5'(i)};
      wd = {32'h0, 32'(i)};
      ra = {5'd0, 5'(i)};
      step();
    end
    read_all();
    clr = 1'b1;
    step();
    clr = 1'b0;
    we = 2'b11;
    wa = {5'd21, 5'd20};
    wd = {32'hEEEE, 32'hFFFF};
    ra = {5'd21, 5'd20};
    wait_ready(31);
    read_all();

    // Reset at sweep cycle 12 restarts the full sweep.
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 12; i++) step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    wait_ready(31);
    read_all();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port successor to the single-write, two-read register file.
- Configurable read/write port counts, hardwired-zero x0, optional same-cycle write-to-read bypass, and a hardware clear sweep after reset or on request.
- Sits between decode (read addresses) and writeback (write ports) of the RISC-V core.
- Exports one debug register (default a0) for the testbench/top level.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADR_WIDTH, 5, address width; DEPTH = 2**ADR_WIDTH entries.
- NUM_READ, 2, number of read ports (1..4).
- NUM_WRITE, 1, number of write ports (1..2).
- BYPASS, 1, when 1, reads return same-cycle write data.
- DEBUG_REG, 10, index exported on dbg_data.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  request a full clear sweep (sampled in READY only).
- ra  in  NUM_READ*ADR_WIDTH  read addresses; port i at bits [i*ADR_WIDTH +: ADR_WIDTH].
- rd  out  NUM_READ*DATA_WIDTH  read data, same packing.
- we  in  NUM_WRITE  write enables, one per port.
- wa  in  NUM_WRITE*ADR_WIDTH  write addresses, packed.
- wd  in  NUM_WRITE*DATA_WIDTH  write data, packed.
- ready  out  1  high when the file is usable; low during the clear sweep.
- dbg_data  out  DATA_WIDTH  stored value of entry DEBUG_REG.

Behaviour:
- FSM states: CLEAR, READY. Sweep counter clr_cnt is ADR_WIDTH bits.
- Reset (rst_n low, async):
  - state=CLEAR, clr_cnt=1, ready=0.
  - Array contents are not reset asynchronously; the sweep zeroes them.
  - rd=0 and dbg_data=0 while in CLEAR.
- CLEAR:
  - Each cycle writes 0 to entry clr_cnt and increments clr_cnt.
  - On the cycle clr_cnt==DEPTH-1 the write completes and state goes to READY next cycle.
  - The sweep therefore takes DEPTH-1 cycles after reset deassertion; ready rises on the following edge.
  - User writes (we) are ignored. clr is ignored. All rd outputs read 0.
- READY:
  - ready=1. A clr high at a rising edge sets state=CLEAR and clr_cnt=1; ready=0 next cycle.
  - A user write in that same cycle is still performed, then swept.
- Reads: combinational, zero-cycle latency.
  - rd[i] = array[ra[i]]; always 0 when ra[i]==0.
  - BYPASS=1: if some port j has we[j]=1, wa[j]==ra[i] and wa[j]!=0, rd[i]=wd[j] in the same cycle. If several ports match, the highest j wins.
  - BYPASS=0: reads show the stored value only; new data is visible the cycle after the edge.
- Writes: on rising clk, for each j with we[j]=1 and wa[j]!=0, array[wa[j]] <= wd[j].
  - Same-address conflict between ports: highest port index wins.
  - A write to x0 is discarded; entry 0 always reads 0, including any debug read.
- dbg_data: stored array[DEBUG_REG], no bypass; 0 in CLEAR; 0 if DEBUG_REG==0.
- Reset mid-sweep restarts the sweep from 1. Reset mid-write discards that write.
- Unconnected/unused ports: when NUM_WRITE=1, all "highest port wins" rules reduce to port 0.

Test Plan:
- Release rst_n, hold ra[0]=5 -> ready=0 and rd[0]=0 for 31 cycles; ready=1 on cycle 32; rd[0]=0.
- READY; we[0]=1, wa[0]=10, wd[0]=0xDEADBEEF, ra[1]=10, BYPASS=1 -> rd[1]=0xDEADBEEF same cycle; dbg_data=0xDEADBEEF next cycle.
  - Same stimulus with BYPASS=0 -> rd[1] shows the old value until the edge.
- NUM_WRITE=2; both ports write address 7 with 0x11 (port 0) and 0x22 (port 1) -> array[7]=0x22; the bypassed rd also shows 0x22.
- Write 0x1234 to x0 -> rd at ra=0 stays 0; no entry is modified.
- Fill x1..x31 with index values, pulse clr -> ready low 31 cycles; afterwards every read returns 0. A we asserted during the sweep leaves its target at 0.
- Assert rst_n low at sweep cycle 12 -> ready stays 0; after release the full 31-cycle sweep reruns from entry 1.
